regfile_sb: RTL and testbench

Parametrised multi-port register file with load scoreboard and same-cycle write bypass. It replaces the single-write, two-read register file in the datapath. It adds:
- a second, late write port for load results
- per-register busy bits, so decode can detect reads of registers with a load still outstanding
- an internal PC-read path with a configurable offset

It sits between decode (read ports, reserve) and writeback (ALU and load write ports).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 37 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and typedefs for the register file
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NRD_DEF    = 3;
  localparam int PC_IDX_DEF = 15;
  localparam int PC_OFS_DEF = 8;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback bus of the register file
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) ();

  logic [NRD-1:0][ADDR_W-1:0] ra;
  logic [NRD-1:0][DATA_W-1:0] rd;
  logic [NRD-1:0]             rd_busy;
  logic [DATA_W-1:0]          pc_in;
  logic                       we_a;
  logic [ADDR_W-1:0]          wa_a;
  logic [DATA_W-1:0]          wd_a;
  logic                       we_b;
  logic [ADDR_W-1:0]          wa_b;
  logic [DATA_W-1:0]          wd_b;
  logic                       rsv_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic                       wr_conflict;

  modport master (
    output ra, pc_in, we_a, wa_a, wd_a, we_b, wa_b, wd_b, rsv_en, rsv_addr,
    input  rd, rd_busy, wr_conflict
  );

  modport slave (
    input  ra, pc_in, we_a, wa_a, wd_a, we_b, wa_b, wd_b, rsv_en, rsv_addr,
    output rd, rd_busy, wr_conflict
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for outstanding loads
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_IDX = PC_IDX_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 we_b,
  input  logic [ADDR_W-1:0]    wa_b,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Release first so a same-address reserve in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (we_b) busy_d[wa_b] = 1'b0;
    if (rsv_en && (rsv_addr != PC_ADDR)) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write, multi-read register file with load scoreboard,
// write bypass and a PC read path on PC_IDX.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int PC_IDX = PC_IDX_DEF,
  parameter int PC_OFS = PC_OFS_DEF
) (
  input logic         clk,
  input logic         reset_n,
  regfile_sb_if.slave bus
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_OFS_W = DATA_W'(PC_OFS);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_conflict_q;
  logic              wr_conflict_d;
  logic [NREG-1:0]   busy;

  // Writes and reserves are dead while reset is held, including the bypass.
  logic we_a_g, we_b_g, rsv_g, wr_a_ok, wr_b_ok;
  assign we_a_g  = bus.we_a & reset_n;
  assign we_b_g  = bus.we_b & reset_n;
  assign rsv_g   = bus.rsv_en & reset_n;
  assign wr_a_ok = we_a_g && (bus.wa_a != PC_ADDR);
  assign wr_b_ok = we_b_g && (bus.wa_b != PC_ADDR);

  // Port B is applied last so the load result wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr_a_ok) regs_d[bus.wa_a] = bus.wd_a;
    if (wr_b_ok) regs_d[bus.wa_b] = bus.wd_b;
    wr_conflict_d = wr_a_ok && wr_b_ok && (bus.wa_a == bus.wa_b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .rsv_en   (rsv_g),
    .rsv_addr (bus.rsv_addr),
    .we_b     (we_b_g),
    .wa_b     (bus.wa_b),
    .busy     (busy)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_pc;
    logic              hit_a;
    logic              hit_b;

    assign addr  = bus.ra[p];
    assign is_pc = (addr == PC_ADDR);
    assign hit_b = we_b_g && (bus.wa_b == addr);
    assign hit_a = we_a_g && (bus.wa_a == addr);

    assign bus.rd[p] = is_pc ? bus.pc_in + PC_OFS_W :
                       hit_b ? bus.wd_b :
                       hit_a ? bus.wd_a :
                               regs_q[addr];

    // A releasing load is being bypassed, so the reader sees valid data.
    assign bus.rd_busy[p] = busy[addr] && !hit_b && !is_pc;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and randomized checks of regfile_sb
// against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int NRD  = NRD_DEF;
  localparam int NREG = 2**ADDR_W_DEF;
  localparam reg_addr_t PCA = reg_addr_t'(PC_IDX_DEF);

  logic clk = 1'b0;
  logic reset_n;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  reg_data_t m_regs [NREG];
  bit        m_busy [NREG];
  bit        m_conf;
  int        vectors;
  int        miscompares;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic reg_data_t exp_rd(input reg_addr_t a);
    if (a == PCA) return bus.pc_in + reg_data_t'(PC_OFS_DEF);
    if (reset_n && bus.we_b && bus.wa_b == a) return bus.wd_b;
    if (reset_n && bus.we_a && bus.wa_a == a) return bus.wd_a;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input reg_addr_t a);
    if (a == PCA) return 1'b0;
    if (reset_n && bus.we_b && bus.wa_b == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_clear();
      return;
    end
    m_conf = bus.we_a && bus.we_b && bus.wa_a == bus.wa_b && bus.wa_a != PCA;
    if (bus.we_a && bus.wa_a != PCA) m_regs[bus.wa_a] = bus.wd_a;
    if (bus.we_b && bus.wa_b != PCA) m_regs[bus.wa_b] = bus.wd_b;
    if (bus.we_b) m_busy[bus.wa_b] = 1'b0;
    if (bus.rsv_en && bus.rsv_addr != PCA) m_busy[bus.rsv_addr] = 1'b1;
  endtask

  task automatic look(input string tag);
    #2;
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s rd%0d", tag, p), 64'(bus.rd[p]), 64'(exp_rd(bus.ra[p])));
      check($sformatf("%s busy%0d", tag, p), 64'(bus.rd_busy[p]), 64'(exp_busy(bus.ra[p])));
    end
    check({tag, " conflict"}, 64'(bus.wr_conflict), 64'(m_conf));
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.we_a   = 1'b0;
    bus.we_b   = 1'b0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2);
    bus.ra[0] = reg_addr_t'(a0);
    bus.ra[1] = reg_addr_t'(a1);
    bus.ra[2] = reg_addr_t'(a2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    idle();
    bus.wa_a     = '0;
    bus.wd_a     = '0;
    bus.wa_b     = '0;
    bus.wd_b     = '0;
    bus.rsv_addr = '0;
    bus.pc_in    = 32'h100;
    set_ra(0, 1, 15);
    model_clear();

    // Held in reset: storage zero, PC path live.
    look("in_reset");
    check("rst_pc", 64'(bus.rd[2]), 64'h108);
    edge_step();
    reset_n = 1'b1;

    for (int i = 0; i < NREG; i++) begin
      set_ra(i, NREG - 1 - i, (i + 5) % NREG);
      look("rst_read");
      edge_step();
    end

    // ALU write with same-cycle bypass.
    bus.we_a = 1'b1; bus.wa_a = 4'd3; bus.wd_a = 32'hDEADBEEF;
    set_ra(3, 15, 0);
    look("wa_byp");
    check("wa_byp_val", 64'(bus.rd[0]), 64'hDEADBEEF);
    edge_step();
    idle();
    look("wa_stored");
    check("wa_stored_val", 64'(bus.rd[0]), 64'hDEADBEEF);
    edge_step();

    // Reserve r5, release it three cycles later.
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd5;
    set_ra(5, 5, 3);
    look("rsv_c1");
    edge_step();
    idle();
    look("rsv_c2");
    check("rsv_busy", 64'(bus.rd_busy[0]), 64'd1);
    edge_step();
    look("rsv_c3");
    edge_step();
    bus.we_b = 1'b1; bus.wa_b = 4'd5; bus.wd_b = 32'h55;
    look("rel_c4");
    check("rel_busy", 64'(bus.rd_busy[0]), 64'd0);
    check("rel_val", 64'(bus.rd[0]), 64'h55);
    edge_step();
    idle();
    look("rel_c5");
    check("rel_after", 64'(bus.rd_busy[1]), 64'd0);
    edge_step();

    // Reserve and release of r7 in one cycle: reserve wins.
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
    bus.we_b = 1'b1; bus.wa_b = 4'd7; bus.wd_b = 32'h77;
    set_ra(7, 7, 7);
    look("rsv_rel");
    edge_step();
    idle();
    look("rsv_rel_after");
    check("rsv_rel_val", 64'(bus.rd[0]), 64'h77);
    check("rsv_rel_busy", 64'(bus.rd_busy[0]), 64'd1);
    edge_step();

    // Both ports to r2: load data wins, one-cycle conflict pulse.
    bus.we_a = 1'b1; bus.wa_a = 4'd2; bus.wd_a = 32'h11;
    bus.we_b = 1'b1; bus.wa_b = 4'd2; bus.wd_b = 32'h22;
    set_ra(2, 2, 0);
    look("conf");
    edge_step();
    idle();
    look("conf_p1");
    check("conf_pulse", 64'(bus.wr_conflict), 64'd1);
    check("conf_val", 64'(bus.rd[0]), 64'h22);
    edge_step();
    look("conf_p2");
    check("conf_gone", 64'(bus.wr_conflict), 64'd0);

    // Writes to the PC index are dropped.
    bus.we_a = 1'b1; bus.wa_a = 4'd15; bus.wd_a = 32'hAAAA;
    bus.we_b = 1'b1; bus.wa_b = 4'd15; bus.wd_b = 32'hBBBB;
    set_ra(15, 2, 15);
    look("pcw");
    check("pcw_rd", 64'(bus.rd[0]), 64'h108);
    edge_step();
    idle();
    look("pcw_after");
    check("pcw_conf", 64'(bus.wr_conflict), 64'd0);
    edge_step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.we_a     = 1'($urandom_range(0, 1));
      bus.wa_a     = reg_addr_t'($urandom);
      bus.wd_a     = reg_data_t'($urandom);
      bus.we_b     = ($urandom_range(0, 2) == 0);
      bus.wa_b     = ($urandom_range(0, 3) == 0) ? bus.wa_a : reg_addr_t'($urandom);
      bus.wd_b     = reg_data_t'($urandom);
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = ($urandom_range(0, 3) == 0) ? bus.wa_b : reg_addr_t'($urandom);
      bus.pc_in    = reg_data_t'($urandom);
      for (int p = 0; p < NRD; p++)
        bus.ra[p] = ($urandom_range(0, 2) == 0) ? bus.wa_b : reg_addr_t'($urandom);
      look("rnd");
      edge_step();
    end

    // Reserve r4, then asynchronous reset between edges.
    idle();
    bus.pc_in = 32'h100;
    bus.we_a = 1'b1; bus.wa_a = 4'd4; bus.wd_a = 32'h4444;
    set_ra(4, 4, 15);
    look("r4_wr");
    edge_step();
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd4;
    look("r4_rsv");
    edge_step();
    idle();
    look("r4_busy");
    check("r4_busy_set", 64'(bus.rd_busy[0]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    check("arst_rd", 64'(bus.rd[0]), 64'd0);
    check("arst_busy", 64'(bus.rd_busy[0]), 64'd0);
    check("arst_pc", 64'(bus.rd[2]), 64'h108);
    @(negedge clk);
    look("in_reset2");
    edge_step();
    reset_n = 1'b1;

    // Late load after reset writes normally.
    bus.we_b = 1'b1; bus.wa_b = 4'd4; bus.wd_b = 32'h4040;
    look("late_ld");
    edge_step();
    idle();
    look("late_ld_after");
    check("late_ld_val", 64'(bus.rd[0]), 64'h4040);
    edge_step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
